// File: rtl/reg_file_wb.sv
// reg_file_wb: writeback-side register file for the RV32IC core.
// 32 x XLEN architectural registers with two combinational read ports,
// one writeback port and a per-register pending scoreboard for RAW stalls.
// x0 reads zero, ignores writes and never becomes pending.
// Optional feature: define REGFILE_BYPASS_EN to forward a same-cycle
// writeback to the read ports and mask its busy flag.
module reg_file_wb #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [$clog2(NREG)-1:0]    rs1_addr,
    input  logic [$clog2(NREG)-1:0]    rs2_addr,
    output logic [XLEN-1:0]            rs1_data,
    output logic [XLEN-1:0]            rs2_data,
    output logic                       rs1_busy,
    output logic                       rs2_busy,
    input  logic                       iss_valid,
    input  logic [$clog2(NREG)-1:0]    iss_rd,
    input  logic                       wb_valid,
    input  logic [$clog2(NREG)-1:0]    wb_rd,
    input  logic [XLEN-1:0]            wb_data,
    input  logic                       flush,
    output logic [$clog2(NREG+1)-1:0]  pend_cnt
);

    localparam int CW = $clog2(NREG + 1);

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] pend;
    logic [NREG-1:0] pend_next;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;
    logic            wb_live;

    assign wb_live = wb_valid && (wb_rd != '0);

    // Architectural register storage; x0 is never written so it stays zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs <= '{default: '0};
        end else if (wb_live) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // Scoreboard next state: flush beats set, set beats clear, so an issue
    // and writeback to the same rd leave the bit owned by the younger issue.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (iss_valid && (iss_rd != '0)) begin
            set_mask[iss_rd] = 1'b1;
        end
        if (wb_valid) begin
            clr_mask[wb_rd] = 1'b1;
        end
        if (flush) begin
            pend_next = '0;
        end else begin
            pend_next = (pend & ~clr_mask) | set_mask;
        end
        pend_next[0] = 1'b0;
    end

    // Pending bits and their registered population count advance together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend     <= '0;
            pend_cnt <= '0;
        end else begin
            pend     <= pend_next;
            pend_cnt <= CW'($countones(pend_next));
        end
    end

    // Read port 1: x0 forced to zero; optional write-through forwarding.
    // Forwarding is gated by rst so outputs stay zero while reset is held.
    always_comb begin
        rs1_data = (rs1_addr == '0) ? '0 : regs[rs1_addr];
        rs1_busy = pend[rs1_addr];
        if (BYPASS && rst && wb_live && (rs1_addr == wb_rd)) begin
            rs1_data = wb_data;
            rs1_busy = 1'b0;
        end
    end

    // Read port 2: same behaviour as read port 1.
    always_comb begin
        rs2_data = (rs2_addr == '0) ? '0 : regs[rs2_addr];
        rs2_busy = pend[rs2_addr];
        if (BYPASS && rst && wb_live && (rs2_addr == wb_rd)) begin
            rs2_data = wb_data;
            rs2_busy = 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_file_wb.sv
// tb_reg_file_wb: table-driven directed vectors for reg_file_wb, plus
// hand-written sequences for a full scoreboard and flush of every register.
// Expected values follow REGFILE_BYPASS_EN when the bench is built with it.
module tb_reg_file_wb;

`ifdef REGFILE_BYPASS_EN
    localparam bit BP = 1'b1;
`else
    localparam bit BP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  rs1_addr = '0;
    logic [4:0]  rs2_addr = '0;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_rd = '0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        flush = 1'b0;
    logic [5:0]  pend_cnt;

    int n_vec = 0;
    int n_bad = 0;

    reg_file_wb #(.XLEN(32), .NREG(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .iss_valid(iss_valid),
        .iss_rd   (iss_rd),
        .wb_valid (wb_valid),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .flush    (flush),
        .pend_cnt (pend_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [4:0]  ird;
        logic        wv;
        logic [4:0]  wrd;
        logic [31:0] wd;
        logic        fl;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        b1;
        logic        b2;
        logic [5:0]  cnt;
    } vec_t;

    vec_t vecs[25];

    function automatic vec_t mk(logic r, logic iv, logic [4:0] ird,
                                logic wv, logic [4:0] wrd, logic [31:0] wd,
                                logic fl, logic [4:0] a1, logic [4:0] a2,
                                logic [31:0] e1, logic [31:0] e2,
                                logic b1, logic b2, logic [5:0] cnt);
        vec_t v;
        v.rst = r;  v.iv = iv; v.ird = ird; v.wv = wv; v.wrd = wrd;
        v.wd = wd;  v.fl = fl; v.a1 = a1;   v.a2 = a2;
        v.e1 = e1;  v.e2 = e2; v.b1 = b1;   v.b2 = b2; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s vec %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic drive_idle();
        rst = 1'b1; iss_valid = 1'b0; iss_rd = '0; wb_valid = 1'b0;
        wb_rd = '0; wb_data = '0; flush = 1'b0;
    endtask

    initial begin
        // Each vector: drive at negedge, check pre-edge outputs, next posedge commits.
        //            rst iv ird   wv wrd  wdata         fl a1  a2   e1/e2 ..., b1 b2 cnt
        vecs[0]  = mk(0, 0, 0,  0, 0,  32'h0,        0, 5,  0,  32'h0, 32'h0, 0, 0, 0);
        vecs[1]  = mk(1, 0, 0,  1, 5,  32'h12345678, 0, 5,  0,
                      BP ? 32'h12345678 : 32'h0, 32'h0, 0, 0, 0);
        vecs[2]  = mk(1, 1, 5,  0, 0,  32'h0,        0, 5,  0,  32'h12345678, 32'h0, 0, 0, 0);
        vecs[3]  = mk(1, 0, 0,  0, 0,  32'h0,        0, 5,  0,  32'h12345678, 32'h0, 1, 0, 1);
        // asynchronous reset mid-run: visible before any clock edge
        vecs[4]  = mk(0, 0, 0,  0, 0,  32'h0,        0, 5,  5,  32'h0, 32'h0, 0, 0, 0);
        vecs[5]  = mk(1, 0, 0,  0, 0,  32'h0,        0, 5,  5,  32'h0, 32'h0, 0, 0, 0);
        // x0: write and issue discarded
        vecs[6]  = mk(1, 1, 0,  1, 0,  32'hDEADBEEF, 0, 0,  0,  32'h0, 32'h0, 0, 0, 0);
        vecs[7]  = mk(1, 0, 0,  0, 0,  32'h0,        0, 0,  0,  32'h0, 32'h0, 0, 0, 0);
        // scoreboard: issue x3, x7, then write back x3
        vecs[8]  = mk(1, 1, 3,  0, 0,  32'h0,        0, 3,  7,  32'h0, 32'h0, 0, 0, 0);
        vecs[9]  = mk(1, 1, 7,  0, 0,  32'h0,        0, 3,  7,  32'h0, 32'h0, 1, 0, 1);
        vecs[10] = mk(1, 0, 0,  1, 3,  32'hA5A50001, 0, 3,  7,
                      BP ? 32'hA5A50001 : 32'h0, 32'h0, !BP, 1, 2);
        vecs[11] = mk(1, 0, 0,  0, 0,  32'h0,        0, 3,  7,  32'hA5A50001, 32'h0, 0, 1, 1);
        // collision: issue and writeback of x9 on the same edge
        vecs[12] = mk(1, 1, 9,  0, 0,  32'h0,        0, 9,  7,  32'h0, 32'h0, 0, 1, 1);
        vecs[13] = mk(1, 1, 9,  1, 9,  32'h55,       0, 9,  7,
                      BP ? 32'h55 : 32'h0, 32'h0, !BP, 1, 2);
        vecs[14] = mk(1, 0, 0,  0, 0,  32'h0,        0, 9,  7,  32'h55, 32'h0, 1, 1, 2);
        // flush with coincident issue of x6 and writeback of x2
        vecs[15] = mk(1, 1, 1,  0, 0,  32'h0,        0, 1,  2,  32'h0, 32'h0, 0, 0, 2);
        vecs[16] = mk(1, 1, 2,  0, 0,  32'h0,        0, 1,  2,  32'h0, 32'h0, 1, 0, 3);
        vecs[17] = mk(1, 1, 4,  0, 0,  32'h0,        0, 4,  2,  32'h0, 32'h0, 0, 1, 4);
        vecs[18] = mk(1, 1, 6,  1, 2,  32'h10,       1, 6,  2,
                      32'h0, BP ? 32'h10 : 32'h0, 0, !BP, 5);
        vecs[19] = mk(1, 0, 0,  0, 0,  32'h0,        0, 6,  2,  32'h0, 32'h10, 0, 0, 0);
        // write-through read of pending x12
        vecs[20] = mk(1, 1, 12, 0, 0,  32'h0,        0, 12, 0,  32'h0, 32'h0, 0, 0, 0);
        vecs[21] = mk(1, 0, 0,  1, 12, 32'hCAFEF00D, 0, 12, 12,
                      BP ? 32'hCAFEF00D : 32'h0, BP ? 32'hCAFEF00D : 32'h0, !BP, !BP, 1);
        vecs[22] = mk(1, 0, 0,  0, 0,  32'h0,        0, 12, 12, 32'hCAFEF00D, 32'hCAFEF00D, 0, 0, 0);
        // writeback to a non-pending register
        vecs[23] = mk(1, 0, 0,  1, 12, 32'h0000BEEF, 0, 3,  9,  32'hA5A50001, 32'h55, 0, 0, 0);
        vecs[24] = mk(1, 0, 0,  0, 0,  32'h0,        0, 12, 2,  32'h0000BEEF, 32'h10, 0, 0, 0);

        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            rst = vecs[i].rst; iss_valid = vecs[i].iv; iss_rd = vecs[i].ird;
            wb_valid = vecs[i].wv; wb_rd = vecs[i].wrd; wb_data = vecs[i].wd;
            flush = vecs[i].fl; rs1_addr = vecs[i].a1; rs2_addr = vecs[i].a2;
            #2;
            chk("rs1_data", i, rs1_data, vecs[i].e1);
            chk("rs2_data", i, rs2_data, vecs[i].e2);
            chk("rs1_busy", i, {31'b0, rs1_busy}, {31'b0, vecs[i].b1});
            chk("rs2_busy", i, {31'b0, rs2_busy}, {31'b0, vecs[i].b2});
            chk("pend_cnt", i, {26'b0, pend_cnt}, {26'b0, vecs[i].cnt});
            n_vec++;
        end

        // Issue every register x1..x31 (x0 too, which must not count).
        for (int r = 0; r < 32; r++) begin
            @(negedge clk);
            drive_idle();
            iss_valid = 1'b1;
            iss_rd = 5'(r);
        end
        @(negedge clk);
        drive_idle();
        rs1_addr = 5'd31; rs2_addr = 5'd1;
        #2;
        chk("full_cnt", 100, {26'b0, pend_cnt}, 32'd31);
        chk("full_busy1", 100, {31'b0, rs1_busy}, 32'd1);
        chk("full_busy2", 100, {31'b0, rs2_busy}, 32'd1);
        n_vec++;

        // Retire x31 alongside a discarded x0 issue.
        @(negedge clk);
        wb_valid = 1'b1; wb_rd = 5'd31; wb_data = 32'h31313131;
        iss_valid = 1'b1; iss_rd = 5'd0;
        @(negedge clk);
        drive_idle();
        rs1_addr = 5'd31; rs2_addr = 5'd30;
        #2;
        chk("retire_cnt", 101, {26'b0, pend_cnt}, 32'd30);
        chk("retire_busy", 101, {31'b0, rs1_busy}, 32'd0);
        chk("retire_data", 101, rs1_data, 32'h31313131);
        chk("other_busy", 101, {31'b0, rs2_busy}, 32'd1);
        n_vec++;

        // Flush everything at once.
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        drive_idle();
        rs1_addr = 5'd17; rs2_addr = 5'd30;
        #2;
        chk("flush_cnt", 102, {26'b0, pend_cnt}, 32'd0);
        chk("flush_busy1", 102, {31'b0, rs1_busy}, 32'd0);
        chk("flush_busy2", 102, {31'b0, rs2_busy}, 32'd0);
        n_vec++;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_file_wb.md
# reg_file_wb

Writeback-side register file for the RV32IC core: the receiving end of the writeback-select path. It accepts the selected Rd result (JAL/JALR link, AUIPC, LUI or memory/ALU value), commits it to one of 32 architectural registers, and serves two combinational read ports to decode. A per-register pending scoreboard tracks registers with an issued but not yet written-back result, so the hazard unit can stall on RAW dependences.

## Interface
Parameters:
- `XLEN`, 32, data width of every register and data port.
- `NREG`, 32, register count; address width is log2(NREG) = 5.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `rs1_addr`  in  5  read port 1 address.
- `rs2_addr`  in  5  read port 2 address.
- `rs1_data`  out  32  read port 1 data, combinational.
- `rs2_data`  out  32  read port 2 data, combinational.
- `rs1_busy`  out  1  pending bit of `rs1_addr`.
- `rs2_busy`  out  1  pending bit of `rs2_addr`.
- `iss_valid`  in  1  an instruction writing `iss_rd` issues this cycle.
- `iss_rd`  in  5  destination of issuing instruction.
- `wb_valid`  in  1  writeback this cycle.
- `wb_rd`  in  5  writeback destination.
- `wb_data`  in  32  writeback data (output of the writeback-select mux).
- `flush`  in  1  clear all pending bits (branch/jump redirect).
- `pend_cnt`  out  6  number of registers currently pending (0..31).

## Operation
- Storage: `NREG` x `XLEN` registers. x0 reads 0 always; writes to x0 are discarded; x0 never becomes pending.
- Write: on rising edge with `wb_valid`=1 and `wb_rd`!=0, `reg[wb_rd]` <= `wb_data`.
- Pending bit per register, next-state priority: `flush` > set > clear.
  - Set: `iss_valid`=1, `iss_rd`!=0, `flush`=0.
  - Clear: `wb_valid`=1 and `wb_rd` matches.
  - Same edge, `iss_rd`==`wb_rd`: data written, bit stays set (younger instruction owns rd).
  - `flush`=1: all bits cleared; a coincident writeback still writes data; a coincident issue is dropped.
- `pend_cnt`: registered population count of pending bits, updated each edge with the bit vector; never exceeds 31.
- Writeback to a non-pending register is legal: data written, bits unchanged.

## Timing
- Reset (`rst`=0, asynchronous): all registers 0, all pending bits 0, `pend_cnt`=0; hence `rs1_data`=`rs2_data`=0 and `rs1_busy`=`rs2_busy`=0 while held. Deassertion takes effect at the next rising edge; reset mid-stream discards all pending state and data.
- Read latency 0 (combinational from address). Write latency 1 edge.
- Busy flags reflect registered pending bits; a pending bit set at edge N is visible from edge N onward.
- Same-cycle read of a register being written: governed by the Configuration macro.

## Configuration
- `REGFILE_BYPASS_EN` defined: when `wb_valid`=1 and `rsX_addr`==`wb_rd`!=0, `rsX_data`=`wb_data` and `rsX_busy`=0 in that same cycle (write-through forwarding).
- Not defined: same-cycle read returns old register value and `rsX_busy` stays at the registered pending bit until the following edge; decode must stall one extra cycle.

## Test plan
- Reset: drive `rst`=0 mid-run after writing x5=0x1234_5678 -> `rs1_data`=0, busy=0, `pend_cnt`=0 immediately; after release read x5 -> 0.
- x0: `wb_valid`=1, `wb_rd`=0, `wb_data`=0xDEAD_BEEF; `iss_rd`=0 -> read x0 = 0, `pend_cnt` unchanged.
- Scoreboard: issue x3, x7 on consecutive edges -> `pend_cnt`=2, `rs1_busy`=1 for x3; writeback x3=0xA5A5_0001 -> x3 reads 0xA5A5_0001, busy=0, `pend_cnt`=1.
- Collision: same edge `iss_rd`=`wb_rd`=9, `wb_data`=0x55 -> x9=0x55, x9 still busy, count unchanged net +0 if it was pending.
- Flush: x1, x2, x4 pending, `flush`=1 with `iss_rd`=6 and writeback x2=0x10 -> `pend_cnt`=0, x6 not busy, x2=0x10.
- Bypass: read x12 while writing x12=0xCAFE_F00D -> with `REGFILE_BYPASS_EN`: 0xCAFE_F00D, busy 0 same cycle; without: old value, busy 1, then new value next cycle.
